two_of_four_tx: RTL and testbench

TWO_OF_FOUR_TX -- requirements
Module: two_of_four_tx

---
 rtl/two_of_four_tx.sv | 141 ++++++++++++++
 tb/tb_two_of_four_tx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/two_of_four_tx.sv
// 2-of-4 codeword transmitter: maps symbols 0..5 onto the six 2-hot nibbles,
// holds each word under valid/ready backpressure, and can auto-sweep all six.
module two_of_four_tx #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sym_valid,
  input  logic [2:0]       sym,
  output logic             sym_ready,
  input  logic             sweep_start,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             cw_valid,
  input  logic             cw_ready,
  output logic             busy,
  output logic             sweep_done,
  output logic             sym_err,
  output logic [7:0]       err_cnt,
  output logic [CNT_W-1:0] tx_cnt
);

  typedef enum logic [1:0] {IDLE, HOLD, SWEEP} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cw_q, cw_d;
  logic [2:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   tx_q, tx_d;
  logic [7:0]         err_q, err_d;
  logic               sym_err_q, sym_err_d;
  logic               done_q, done_d;
  logic               rdy, accept, legal;

  function automatic logic [3:0] enc(input logic [2:0] s);
    case (s)
      3'd0:    enc = 4'b0011;
      3'd1:    enc = 4'b0101;
      3'd2:    enc = 4'b0110;
      3'd3:    enc = 4'b1001;
      3'd4:    enc = 4'b1010;
      3'd5:    enc = 4'b1100;
      default: enc = 4'b0000;
    endcase
  endfunction

  // A new symbol may be taken in IDLE, or in HOLD when the current word leaves.
  assign rdy    = (state_q == IDLE) || (state_q == HOLD && cw_ready);
  assign accept = sym_valid && rdy;
  assign legal  = (sym < 3'd6);

  always_comb begin
    state_d   = state_q;
    cw_d      = cw_q;
    idx_d     = idx_q;
    tx_d      = tx_q;
    err_d     = err_q;
    sym_err_d = 1'b0;
    done_d    = 1'b0;

    if (accept && !legal) begin
      sym_err_d = 1'b1;
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (sym_valid) begin
          if (legal) begin
            state_d = HOLD;
            cw_d    = enc(sym);
          end
        end else if (sweep_start) begin
          state_d = SWEEP;
          idx_d   = 3'd0;
          cw_d    = enc(3'd0);
        end
      end
      HOLD: begin
        if (cw_ready) begin
          tx_d    = tx_q + CNT_W'(1);
          state_d = IDLE;
          cw_d    = 4'b0000;
          if (sym_valid && legal) begin
            state_d = HOLD;
            cw_d    = enc(sym);
          end
        end
      end
      SWEEP: begin
        if (cw_ready) begin
          tx_d = tx_q + CNT_W'(1);
          if (idx_q == 3'd5) begin
            state_d = IDLE;
            cw_d    = 4'b0000;
            idx_d   = 3'd0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            cw_d  = enc(idx_q + 3'd1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cw_d    = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cw_q      <= 4'b0000;
      idx_q     <= 3'd0;
      tx_q      <= '0;
      err_q     <= 8'd0;
      sym_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cw_q      <= cw_d;
      idx_q     <= idx_d;
      tx_q      <= tx_d;
      err_q     <= err_d;
      sym_err_q <= sym_err_d;
      done_q    <= done_d;
    end
  end

  assign sym_ready    = rst_n && rdy;
  assign {a, b, c, d} = cw_q;
  assign cw_valid     = (state_q != IDLE);
  assign busy         = (state_q == SWEEP);
  assign sweep_done   = done_q;
  assign sym_err      = sym_err_q;
  assign err_cnt      = err_q;
  assign tx_cnt       = tx_q;

endmodule

// File: tb/tb_two_of_four_tx.sv
// Directed bench for two_of_four_tx: hand-derived expectations for latency,
// backpressure, streaming, sweep, illegal symbols and reset mid-sweep.
module tb_two_of_four_tx;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sym_valid;
  logic [2:0]       sym;
  logic             sym_ready;
  logic             sweep_start;
  logic             a, b, c, d;
  logic             cw_valid;
  logic             cw_ready;
  logic             busy;
  logic             sweep_done;
  logic             sym_err;
  logic [7:0]       err_cnt;
  logic [CNT_W-1:0] tx_cnt;

  int vecs = 0;
  int errs = 0;

  logic [3:0] cw_tab [6];
  logic [3:0] abcd;
  assign abcd = {a, b, c, d};

  two_of_four_tx #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym(sym),
    .sym_ready(sym_ready), .sweep_start(sweep_start),
    .a(a), .b(b), .c(c), .d(d), .cw_valid(cw_valid), .cw_ready(cw_ready),
    .busy(busy), .sweep_done(sweep_done), .sym_err(sym_err),
    .err_cnt(err_cnt), .tx_cnt(tx_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int pulses;
  int cw_seen;

  initial begin
    cw_tab[0] = 4'b0011; cw_tab[1] = 4'b0101; cw_tab[2] = 4'b0110;
    cw_tab[3] = 4'b1001; cw_tab[4] = 4'b1010; cw_tab[5] = 4'b1100;

    rst_n = 1'b0; sym_valid = 1'b0; sym = 3'd0; sweep_start = 1'b0; cw_ready = 1'b0;
    #3;
    chk("rst_cw_valid", cw_valid, 0);
    chk("rst_abcd", abcd, 0);
    chk("rst_sym_ready", sym_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnts", {err_cnt, tx_cnt}, 0);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("post_rst_ready", sym_ready, 1);
    step();

    // Single-symbol latency
    cw_ready = 1'b1; sym_valid = 1'b1; sym = 3'd4;
    step();
    sym_valid = 1'b0;
    chk("lat_valid", cw_valid, 1);
    chk("lat_abcd", abcd, 4'b1010);
    chk("lat_tx0", tx_cnt, 0);
    step();
    chk("lat_drop", cw_valid, 0);
    chk("lat_abcd0", abcd, 0);
    chk("lat_tx1", tx_cnt, 1);

    // Backpressure
    cw_ready = 1'b0; sym_valid = 1'b1; sym = 3'd2;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_abcd", abcd, 4'b0110);
      chk("bp_valid", cw_valid, 1);
      chk("bp_ready", sym_ready, 0);
      chk("bp_tx", tx_cnt, 1);
      step();
    end
    sym_valid = 1'b0; cw_ready = 1'b1;
    step();
    chk("bp_release_tx", tx_cnt, 2);
    chk("bp_release_valid", cw_valid, 0);
    step();
    chk("bp_tx_once", tx_cnt, 2);

    // Streaming 0..5
    for (int i = 0; i < 6; i++) begin
      sym_valid = 1'b1; sym = 3'(i);
      step();
      chk("str_abcd", abcd, cw_tab[i]);
      chk("str_2hot", $countones(abcd), 2);
      chk("str_valid", cw_valid, 1);
    end
    sym_valid = 1'b0;
    step();
    chk("str_end_valid", cw_valid, 0);
    chk("str_tx", tx_cnt, 8);

    // Sweep with toggling cw_ready, sym_valid asserted but ignored
    cw_ready = 1'b0; sweep_start = 1'b1;
    step();
    sweep_start = 1'b0; sym_valid = 1'b1; sym = 3'd3;
    for (int k = 0; k < 6; k++) begin
      chk("sw_abcd", abcd, cw_tab[k]);
      chk("sw_busy", busy, 1);
      chk("sw_done_low", sweep_done, 0);
      step();
      chk("sw_hold", abcd, cw_tab[k]);
      cw_ready = 1'b1;
      chk("sw_ready_low", sym_ready, 0);
      if (k == 5) sym_valid = 1'b0;
      step();
      cw_ready = 1'b0;
    end
    chk("sw_done", sweep_done, 1);
    chk("sw_busy_drop", busy, 0);
    chk("sw_valid_drop", cw_valid, 0);
    step();
    chk("sw_done_pulse", sweep_done, 0);
    chk("sw_tx", tx_cnt, 14);

    // Illegal symbols, 300 alternating 6/7, saturating err_cnt
    cw_ready = 1'b1; pulses = 0; cw_seen = 0;
    for (int i = 0; i < 300; i++) begin
      sym_valid = 1'b1; sym = (i % 2 == 0) ? 3'd6 : 3'd7;
      step();
      sym_valid = 1'b0;
      if (sym_err) pulses++;
      if (cw_valid) cw_seen++;
      if (i == 253) chk("ill_err254", err_cnt, 254);
      if (i == 254) chk("ill_err255", err_cnt, 255);
      step();
      if (sym_err) pulses += 1000;
      if (cw_valid) cw_seen++;
    end
    chk("ill_pulses", pulses, 300);
    chk("ill_sat", err_cnt, 255);
    chk("ill_no_cw", cw_seen, 0);
    chk("ill_tx", tx_cnt, 14);

    // Reset mid-sweep after the third word completes
    sweep_start = 1'b1; cw_ready = 1'b1;
    step();
    sweep_start = 1'b0;
    step(); step(); step();
    chk("rs_word4", abcd, 4'b1001);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_abcd", abcd, 0);
    chk("rs_valid", cw_valid, 0);
    chk("rs_busy", busy, 0);
    chk("rs_ready", sym_ready, 0);
    chk("rs_cnts", {err_cnt, tx_cnt}, 0);
    step();
    chk("rs_held", cw_valid, 0);
    #3 rst_n = 1'b1;
    #1 chk("rs_rel_ready", sym_ready, 1);
    cw_ready = 1'b0; sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    chk("rs_restart", abcd, 4'b0011);
    chk("rs_restart_busy", busy, 1);
    chk("rs_restart_tx", tx_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
